// File: rtl/fifo_out_ctrl_pkg.sv
// Shared definitions for the weight FIFO bank controllers (fill side and read side).
// Holds the FSM state type, FIFO read latency and default array geometry.
package weight_fifo_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Cycles from a pop to valid data on fifo_rd_data; the fill controller relies on it too.
    localparam int RD_LATENCY = 1;

    localparam int DEF_FIFO_WIDTH = 16;
    localparam int DEF_SYS_ROW    = 16;
    localparam int DEF_DATA_WIDTH = 16;
    localparam int REPEAT_WIDTH   = 16;

    function automatic int beat_width(input int sys_row, input int fifo_width);
        return $clog2(sys_row + fifo_width);
    endfunction

endpackage

// File: rtl/fifo_out_ctrl_if.sv
// FIFO-bank read port plus systolic-array weight port of the read-side controller.
interface fifo_out_ctrl_if
    import weight_fifo_pkg::*;
#(
    parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

    // fifo_rd_en[c] pops column c; it is only raised when no active column is empty,
    // and the popped word appears on fifo_rd_data one cycle later. w_valid[c] qualifies
    // w_data[c] for one cycle; w_load marks a completely shifted-in tile.
    logic [FIFO_WIDTH-1:0]            fifo_empty;
    logic [FIFO_WIDTH-1:0]            fifo_rd_en;
    logic [FIFO_WIDTH*DATA_WIDTH-1:0] fifo_rd_data;
    logic [FIFO_WIDTH*DATA_WIDTH-1:0] w_data;
    logic [FIFO_WIDTH-1:0]            w_valid;
    logic                             w_load;

    modport master (
        input  fifo_empty,
        input  fifo_rd_data,
        output fifo_rd_en,
        output w_data,
        output w_valid,
        output w_load
    );

    modport slave (
        output fifo_empty,
        output fifo_rd_data,
        input  fifo_rd_en,
        input  w_data,
        input  w_valid,
        input  w_load
    );

endinterface

// File: rtl/fifo_out_ctrl_skew_mask_gen.sv
// Maps the current beat to the set of columns inside their diagonal-skew window:
// column c is active for beats c .. c+SYS_ROW-1.
module skew_mask_gen #(
    parameter int FIFO_WIDTH = 16,
    parameter int SYS_ROW    = 16,
    parameter int BEAT_WIDTH = 5
) (
    input  logic [BEAT_WIDTH-1:0] beat,
    output logic [FIFO_WIDTH-1:0] mask
);

    logic [31:0] beat_ext;

    always_comb begin
        mask     = '0;
        beat_ext = 32'(beat);
        for (int c = 0; c < FIFO_WIDTH; c++) begin
            mask[c] = (beat_ext >= 32'(c)) && (beat_ext < 32'(c + SYS_ROW));
        end
    end

endmodule

// File: rtl/fifo_out_ctrl.sv
// Read-side controller of the weight FIFO bank: pops skewed columns tile by tile,
// stalls on underflow, registers weights into the array and strobes w_load / done.
module fifo_out_ctrl
    import weight_fifo_pkg::*;
#(
    parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
    parameter int SYS_ROW    = DEF_SYS_ROW,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [REPEAT_WIDTH-1:0] repeat_cnt,
    fifo_out_ctrl_if.master         bus,
    output logic                    busy,
    output logic                    done,
    output state_t                  dbg_state
);

    localparam int BEAT_WIDTH = beat_width(SYS_ROW, FIFO_WIDTH);
    localparam logic [BEAT_WIDTH-1:0] LAST_BEAT = BEAT_WIDTH'(SYS_ROW + FIFO_WIDTH - 2);

    state_t                    state_q, state_d;
    logic [BEAT_WIDTH-1:0]     beat_q, beat_d;
    logic [REPEAT_WIDTH-1:0]   tile_q, tile_d;
    logic [REPEAT_WIDTH-1:0]   rep_q, rep_d;
    logic                      busy_d, done_d;

    logic [FIFO_WIDTH-1:0]     active;
    logic [FIFO_WIDTH-1:0]     rd_en;
    logic                      stall, pop, last_beat, final_tile, tile_end;

    logic [RD_LATENCY-1:0][FIFO_WIDTH-1:0] pop_pipe;
    logic [RD_LATENCY-1:0]                 end_pipe, fin_pipe;
    logic                                  end_d, fin_d;
    logic [FIFO_WIDTH*DATA_WIDTH-1:0]      w_data_q;
    logic [FIFO_WIDTH-1:0]                 w_valid_q;
    logic                                  w_load_q;

    skew_mask_gen #(
        .FIFO_WIDTH (FIFO_WIDTH),
        .SYS_ROW    (SYS_ROW),
        .BEAT_WIDTH (BEAT_WIDTH)
    ) u_skew_mask_gen (
        .beat (beat_q),
        .mask (active)
    );

    // The pop decision follows the live empty flags so a column is never popped while empty.
    assign stall      = |(active & bus.fifo_empty);
    assign pop        = (state_q == RUN) && !stall;
    assign rd_en      = pop ? active : '0;
    assign last_beat  = (beat_q == LAST_BEAT);
    assign final_tile = (tile_q == rep_q - REPEAT_WIDTH'(1));
    assign tile_end   = pop && last_beat;

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        tile_d  = tile_q;
        rep_d   = rep_q;
        busy_d  = busy;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (en) begin
                    if (repeat_cnt != '0) begin
                        rep_d   = repeat_cnt;
                        beat_d  = '0;
                        tile_d  = '0;
                        busy_d  = 1'b1;
                        state_d = RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (pop) begin
                    if (last_beat) begin
                        beat_d = '0;
                        if (final_tile) begin
                            state_d = DRAIN;
                        end else begin
                            tile_d = tile_q + REPEAT_WIDTH'(1);
                        end
                    end else begin
                        beat_d = beat_q + BEAT_WIDTH'(1);
                    end
                end
            end
            DRAIN: begin
                // Wait for the final tile's marker; done lands together with its w_load.
                if (end_d && fin_d) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            tile_q  <= '0;
            rep_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            tile_q  <= tile_d;
            rep_q   <= rep_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    // Pops and tile-end markers travel the same delay so w_load trails the last column.
    always_ff @(posedge clk) begin
        if (rst) begin
            pop_pipe  <= '0;
            end_pipe  <= '0;
            fin_pipe  <= '0;
            end_d     <= 1'b0;
            fin_d     <= 1'b0;
            w_data_q  <= '0;
            w_valid_q <= '0;
            w_load_q  <= 1'b0;
        end else begin
            pop_pipe[0] <= rd_en;
            end_pipe[0] <= tile_end;
            fin_pipe[0] <= tile_end && final_tile;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pop_pipe[i] <= pop_pipe[i-1];
                end_pipe[i] <= end_pipe[i-1];
                fin_pipe[i] <= fin_pipe[i-1];
            end
            w_valid_q <= pop_pipe[RD_LATENCY-1];
            end_d     <= end_pipe[RD_LATENCY-1];
            fin_d     <= fin_pipe[RD_LATENCY-1];
            w_load_q  <= end_d;
            for (int c = 0; c < FIFO_WIDTH; c++) begin
                if (pop_pipe[RD_LATENCY-1][c]) begin
                    w_data_q[c*DATA_WIDTH +: DATA_WIDTH] <= bus.fifo_rd_data[c*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    assign bus.fifo_rd_en = rd_en;
    assign bus.w_data     = w_data_q;
    assign bus.w_valid    = w_valid_q;
    assign bus.w_load     = w_load_q;
    assign dbg_state      = state_q;

endmodule
